// File: rtl/cv32e40s_data_obi_arbiter.sv
// cv32e40s_data_obi_arbiter
// Shares the data-side OBI transaction port between the LSU (port 0) and a
// secondary master (port 1). It arbitrates the A channel, bounds the number of
// outstanding transactions, and routes in-order responses back through an ID FIFO.
// Define CV32E40S_DOBI_ARB_RR_EN for round-robin arbitration. When it is left
// undefined, the arbiter uses fixed priority and port 0 always wins.
//
// There is no multi-state FSM here. The only sequencing state is the lock:
//   state    | meaning
//   unlocked | grant follows arbitration of the current valids
//   locked   | an offered request stalled; grant held on lock_id until handshake
module cv32e40s_data_obi_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int REQ_W           = 69,
  parameter int RESP_W          = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [REQ_W-1:0]  req0_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [REQ_W-1:0]  req1_i,
  output logic              resp0_valid_o,
  output logic [RESP_W-1:0] resp0_o,
  output logic              resp1_valid_o,
  output logic [RESP_W-1:0] resp1_o,
  output logic              trans_valid_o,
  input  logic              trans_ready_i,
  output logic [REQ_W-1:0]  trans_o,
  input  logic              resp_valid_i,
  input  logic [RESP_W-1:0] resp_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  logic [CNT_W-1:0]           r_cnt;
  logic [MAX_OUTSTANDING-1:0] r_fifo;
  logic [PTR_W-1:0]           r_wptr;
  logic [PTR_W-1:0]           r_rptr;
  logic                       r_lock;
  logic                       r_lock_id;
`ifdef CV32E40S_DOBI_ARB_RR_EN
  logic                       r_rr_last;
`endif

  logic w_grant;
  logic w_valid;
  logic w_hs;
  logic w_pop;
  logic w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Grant selection: a stalled request keeps its grant so that OBI addr/req stay stable.
  always_comb begin
    w_grant = 1'b0;
    if (r_lock) begin
      w_grant = r_lock_id;
    end else if (req0_valid_i && req1_valid_i) begin
`ifdef CV32E40S_DOBI_ARB_RR_EN
      w_grant = ~r_rr_last;
`else
      w_grant = 1'b0;
`endif
    end else begin
      w_grant = req1_valid_i & ~req0_valid_i;
    end
  end

  // The combinational datapath. Every output is forced low while reset is held.
  always_comb begin
    w_valid       = ~rst & (req0_valid_i | req1_valid_i) & (r_cnt < MAX_CNT);
    w_hs          = w_valid & trans_ready_i;
    // A response arriving with nothing outstanding is dropped, so the counter cannot underflow.
    w_pop         = ~rst & resp_valid_i & (r_cnt != '0);
    w_head        = r_fifo[r_rptr];
    trans_valid_o = w_valid;
    trans_o       = rst ? '0 : (w_grant ? req1_i : req0_i);
    req0_ready_o  = w_hs & ~w_grant;
    req1_ready_o  = w_hs & w_grant;
    resp0_valid_o = w_pop & ~w_head;
    resp1_valid_o = w_pop & w_head;
    resp0_o       = rst ? '0 : resp_i;
    resp1_o       = rst ? '0 : resp_i;
  end

  // Outstanding counter and ID FIFO. A push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_fifo <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_hs && !w_pop) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!w_hs && w_pop) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_hs) begin
        r_fifo[r_wptr] <= w_grant;
        r_wptr         <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
    end
  end

  // Lock: set when a request is offered but not accepted, and clear on the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
    end else if (w_hs) begin
      r_lock    <= 1'b0;
    end else if (w_valid) begin
      r_lock    <= 1'b1;
      r_lock_id <= w_grant;
    end
  end

`ifdef CV32E40S_DOBI_ARB_RR_EN
  // Round-robin history. It resets to 1 so that port 0 wins the first contested grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_last <= 1'b1;
    end else if (w_hs) begin
      r_rr_last <= w_grant;
    end
  end
`endif

`ifndef SYNTHESIS
  a_req0_hold: assert property (@(posedge clk) disable iff (rst)
    (req0_valid_i && !req0_ready_o) |=> (req0_valid_i && $stable(req0_i)));
  a_req1_hold: assert property (@(posedge clk) disable iff (rst)
    (req1_valid_i && !req1_ready_o) |=> (req1_valid_i && $stable(req1_i)));
  a_resp_empty: assert property (@(posedge clk) disable iff (rst)
    resp_valid_i |-> (r_cnt != '0));
`endif

endmodule

// File: tb/tb_cv32e40s_data_obi_arbiter.sv
// Bench for cv32e40s_data_obi_arbiter: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_cv32e40s_data_obi_arbiter;
  localparam int REQ_W  = 69;
  localparam int RESP_W = 33;
  localparam int MAXO   = 2;
`ifdef CV32E40S_DOBI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic v0, v1, r0, r1, tr, rv, tv, r0v, r1v;
  logic [REQ_W-1:0]  p0, p1, to;
  logic [RESP_W-1:0] rd, ro0, ro1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cv32e40s_data_obi_arbiter #(.MAX_OUTSTANDING(MAXO), .REQ_W(REQ_W), .RESP_W(RESP_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(v0), .req0_ready_o(r0), .req0_i(p0),
    .req1_valid_i(v1), .req1_ready_o(r1), .req1_i(p1),
    .resp0_valid_o(r0v), .resp0_o(ro0),
    .resp1_valid_o(r1v), .resp1_o(ro1),
    .trans_valid_o(tv), .trans_ready_i(tr), .trans_o(to),
    .resp_valid_i(rv), .resp_i(rd)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of issuing ports, a stalled-port marker and the last winner.
  int q[$];
  int stuck = -1;
  int last  = 1;

  always @(negedge clk) begin : cmp
    int  g;
    bit  e_tv, e_pop, e_hs;
    if (rst) begin
      chk("m_rst_tvalid", tv, 0);
      chk("m_rst_rdy0", r0, 0);
      chk("m_rst_rdy1", r1, 0);
      chk("m_rst_r0v", r0v, 0);
      chk("m_rst_r1v", r1v, 0);
      chk("m_rst_trans", to, 0);
      chk("m_rst_resp0", ro0, 0);
      chk("m_rst_resp1", ro1, 0);
      q.delete();
      stuck = -1;
      last  = 1;
    end else begin
      e_tv = (v0 || v1) && (q.size() < MAXO);
      if (stuck >= 0)     g = stuck;
      else if (v0 && v1)  g = RR ? 1 - last : 0;
      else                g = v0 ? 0 : 1;
      e_pop = rv && (q.size() > 0);
      e_hs  = e_tv && tr;
      chk("m_tvalid", tv, e_tv);
      chk("m_rdy0", r0, e_hs && g == 0);
      chk("m_rdy1", r1, e_hs && g == 1);
      if (e_tv) chk("m_trans", to, (g == 1) ? p1 : p0);
      chk("m_r0v", r0v, e_pop && q[0] == 0);
      chk("m_r1v", r1v, e_pop && q[0] == 1);
      chk("m_resp0", ro0, rd);
      chk("m_resp1", ro1, rd);
      chk("m_cnt", dut.r_cnt, q.size());
      if (e_pop) void'(q.pop_front());
      if (e_hs) begin
        q.push_back(g);
        last  = g;
        stuck = -1;
      end else if (e_tv) begin
        stuck = g;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] e_g;
    rst = 1'b1; v0 = 0; v1 = 0; p0 = '0; p1 = '0; tr = 0; rv = 0; rd = '0;
    repeat (2) nxt();

    // Requests held during reset must be invisible, then accepted once reset releases.
    v0 = 1; p0 = 69'h0_AAAA_0001_1111_0001; tr = 1;
    @(negedge clk); chk("rst_tvalid", tv, 0); chk("rst_rdy0", r0, 0);
    nxt(); rst = 0;
    @(negedge clk); chk("first_tvalid", tv, 1); chk("first_rdy0", r0, 1);
    chk("first_trans", to, 69'h0_AAAA_0001_1111_0001);
    nxt(); v0 = 0; rv = 1; rd = 33'h1_0000_00A1;
    @(negedge clk); chk("first_r0v", r0v, 1); chk("first_resp0", ro0, 33'h1_0000_00A1);
    nxt(); rv = 0;

    // T1: port 1 stalls, and port 0 arriving later must not steal the grant.
    v1 = 1; p1 = 69'h0_BBBB_0002_2222_0002; tr = 0;
    @(negedge clk); chk("t1_c1_trans", to, 69'h0_BBBB_0002_2222_0002);
    nxt(); v0 = 1; p0 = 69'h0_CCCC_0003_3333_0003;
    @(negedge clk); chk("t1_c2_trans", to, 69'h0_BBBB_0002_2222_0002); chk("t1_c2_rdy0", r0, 0);
    nxt();
    @(negedge clk); chk("t1_c3_trans", to, 69'h0_BBBB_0002_2222_0002);
    nxt(); tr = 1;
    @(negedge clk); chk("t1_c4_rdy1", r1, 1); chk("t1_c4_rdy0", r0, 0);
    nxt(); v1 = 0;
    @(negedge clk); chk("t1_c5_rdy0", r0, 1); chk("t1_c5_trans", to, 69'h0_CCCC_0003_3333_0003);
    nxt();

    // T2: two transactions are outstanding, so the third request is held off until a response.
    p0 = 69'h0_DDDD_0004_4444_0004;
    @(negedge clk); chk("t2_tvalid", tv, 0); chk("t2_rdy0", r0, 0); chk("t2_cnt", dut.r_cnt, 2);
    nxt(); rv = 1; rd = 33'h0_0000_00B2;
    @(negedge clk); chk("t2_r1v", r1v, 1); chk("t2_tvalid_still", tv, 0);
    nxt(); rv = 0;
    @(negedge clk); chk("t2_tvalid_after", tv, 1); chk("t2_cnt_after", dut.r_cnt, 1);
    chk("t2_rdy0_after", r0, 1);
    nxt(); v0 = 0; rv = 1; rd = 33'h0_0000_00C3;
    repeat (2) nxt();
    rv = 0;

    // T3 and T4: in-order response routing, with a push and a pop in the same cycle.
    v0 = 1; p0 = 69'h0_EEEE_0005_5555_0005; nxt();
    v0 = 0; v1 = 1; p1 = 69'h0_FFFF_0006_6666_0006; nxt();
    v1 = 0; rv = 1; rd = 33'h1_2345_6784;
    @(negedge clk); chk("t3_a_r0v", r0v, 1); chk("t3_a_r1v", r1v, 0);
    chk("t3_a_resp0", ro0, 33'h1_2345_6784); chk("t3_a_resp1", ro1, 33'h1_2345_6784);
    nxt(); v0 = 1; p0 = 69'h0_1234_0007_7777_0007; rd = 33'h0_8765_4325;
    @(negedge clk); chk("t3_b_r1v", r1v, 1); chk("t3_b_r0v", r0v, 0);
    chk("t4_rdy0", r0, 1); chk("t4_cnt", dut.r_cnt, 1);
    nxt(); v0 = 0; rd = 33'h1_0F0F_0F06;
    @(negedge clk); chk("t4_cnt_same", dut.r_cnt, 1); chk("t3_c_r0v", r0v, 1);
    nxt(); rv = 0;

    // A single port 1 transaction leaves port 1 as the last winner before T5.
    v1 = 1; p1 = 69'h0_5A5A_0008_8888_0008; nxt();
    v1 = 0; rv = 1; nxt(); rv = 0;

    // T5: both ports request continuously.
    v0 = 1; v1 = 1; p0 = 69'h0_0000_0009_9999_0009; p1 = 69'h0_0000_000A_AAAA_000A; tr = 1;
    for (int i = 0; i < 4; i++) begin
      rv = (i > 0);
      e_g = (RR && (i % 2 == 1)) ? 2'b10 : 2'b01;
      @(negedge clk); chk($sformatf("t5_grant%0d", i), {r1, r0}, e_g);
      nxt();
    end
    if (RR) v1 = 0; else v0 = 0;
    rv = 1; nxt();
    v0 = 0; v1 = 0; nxt();
    rv = 0;

    // T6: reset pulse while a transaction is outstanding and a stalled request holds the lock.
    v0 = 1; p0 = 69'h0_0000_000B_BBBB_000B; nxt();
    v0 = 0; v1 = 1; p1 = 69'h0_0000_000C_CCCC_000C; tr = 0; nxt();
    rst = 1; rv = 1; rd = 33'h1_FFFF_FFFF; v0 = 1; p0 = 69'h0_0000_000D_DDDD_000D;
    @(negedge clk); chk("t6_tvalid", tv, 0); chk("t6_rdy1", r1, 0); chk("t6_r0v", r0v, 0);
    chk("t6_r1v", r1v, 0); chk("t6_trans", to, 0); chk("t6_resp0", ro0, 0); chk("t6_cnt", dut.r_cnt, 0);
    nxt(); rst = 0; rv = 0; tr = 1;
    @(negedge clk); chk("t6_tvalid_after", tv, 1); chk("t6_rdy0_after", r0, 1);
    chk("t6_cnt_after", dut.r_cnt, 0);
    nxt(); v0 = 0;
    @(negedge clk); chk("t6_rdy1_after", r1, 1);
    nxt(); v1 = 0; rv = 1; repeat (2) nxt();
    rv = 0; nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
